hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 158 +++++++++++++++
 tb/tb_hazard_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use interlock, branch flush, data-memory
// wait/timeout handling and stall/flush performance counters.
module hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           idLHSRegisterIndex,
  input  logic [4:0]           idRHSRegisterIndex,
  input  logic                 idUsesLHS,
  input  logic                 idUsesRHS,
  input  logic                 exMemRead,
  input  logic [4:0]           exWriteRegisterIndex,
  input  logic                 exBranchTaken,
  input  logic                 memRequest,
  input  logic                 memReady,
  output logic                 pcDontUpdate,
  output logic                 ifIdDontUpdate,
  output logic                 idExDontUpdate,
  output logic                 exMemDontUpdate,
  output logic                 ifIdFlush,
  output logic                 idExFlush,
  output logic                 memWbBubble,
  output logic [CNT_WIDTH-1:0] stallCycles,
  output logic [CNT_WIDTH-1:0] flushCount,
  output logic                 timeoutError
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [7:0]           TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [7:0]           wait_count_q, wait_count_d;
  logic                 timeout_error_q, timeout_error_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

  logic mem_stall;
  logic load_use;
  logic branch_flush;

  // Hazard detection terms
  always_comb begin
    mem_stall = (state_q == MEM_WAIT) ||
                ((state_q == RUN) && memRequest && !memReady);
    load_use  = exMemRead && (exWriteRegisterIndex != 5'd0) &&
                ((idUsesLHS && (idLHSRegisterIndex == exWriteRegisterIndex)) ||
                 (idUsesRHS && (idRHSRegisterIndex == exWriteRegisterIndex)));
  end

  // State, wait counter and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= RUN;
      wait_count_q    <= '0;
      timeout_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_count_q    <= wait_count_d;
      timeout_error_q <= timeout_error_d;
    end
  end

  // Next-state: memory wait tracking and timeout detection
  always_comb begin
    state_d         = state_q;
    wait_count_d    = wait_count_q;
    timeout_error_d = timeout_error_q;
    case (state_q)
      RUN: begin
        if (memRequest && !memReady) begin
          state_d      = MEM_WAIT;
          wait_count_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (memReady) begin
          state_d      = RUN;
          wait_count_d = '0;
        end else if (wait_count_q == TIMEOUT_LIMIT) begin
          state_d         = ERROR;
          timeout_error_d = 1'b1;
        end else begin
          wait_count_d = wait_count_q + 8'd1;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d      = RUN;
        wait_count_d = '0;
      end
    endcase
  end

  // Control outputs by priority: error/memory stall, branch, load-use
  always_comb begin
    pcDontUpdate    = 1'b0;
    ifIdDontUpdate  = 1'b0;
    idExDontUpdate  = 1'b0;
    exMemDontUpdate = 1'b0;
    ifIdFlush       = 1'b0;
    idExFlush       = 1'b0;
    memWbBubble     = 1'b0;
    branch_flush    = 1'b0;
    if ((state_q == ERROR) || mem_stall) begin
      pcDontUpdate    = 1'b1;
      ifIdDontUpdate  = 1'b1;
      idExDontUpdate  = 1'b1;
      exMemDontUpdate = 1'b1;
      memWbBubble     = 1'b1;
    end else if (exBranchTaken) begin
      ifIdFlush    = 1'b1;
      idExFlush    = 1'b1;
      branch_flush = 1'b1;
    end else if (load_use) begin
      pcDontUpdate   = 1'b1;
      ifIdDontUpdate = 1'b1;
      idExFlush      = 1'b1;
    end
  end

  // Saturating counter next values
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (pcDontUpdate && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_ONE;
    end
    if (branch_flush && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_ONE;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stallCycles  = stall_cycles_q;
  assign flushCount   = flush_count_q;
  assign timeoutError = timeout_error_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MEM_TIMEOUT=4, 4-bit counters).
module tb_hazard_controller;

  logic       clk;
  logic       rst;
  logic [4:0] idLHSRegisterIndex;
  logic [4:0] idRHSRegisterIndex;
  logic       idUsesLHS;
  logic       idUsesRHS;
  logic       exMemRead;
  logic [4:0] exWriteRegisterIndex;
  logic       exBranchTaken;
  logic       memRequest;
  logic       memReady;
  logic       pcDontUpdate;
  logic       ifIdDontUpdate;
  logic       idExDontUpdate;
  logic       exMemDontUpdate;
  logic       ifIdFlush;
  logic       idExFlush;
  logic       memWbBubble;
  logic [3:0] stallCycles;
  logic [3:0] flushCount;
  logic       timeoutError;

  int passed;
  int total;

  // {pc, ifId, idEx, exMem dont-update, ifIdFlush, idExFlush, memWbBubble}
  logic [6:0] ctl;
  assign ctl = {pcDontUpdate, ifIdDontUpdate, idExDontUpdate, exMemDontUpdate,
                ifIdFlush, idExFlush, memWbBubble};

  localparam logic [6:0] CTL_NONE   = 7'b0000000;
  localparam logic [6:0] CTL_STALL  = 7'b1111001;
  localparam logic [6:0] CTL_BRANCH = 7'b0000110;
  localparam logic [6:0] CTL_LOADUSE = 7'b1100010;

  hazard_controller #(
    .MEM_TIMEOUT(4),
    .CNT_WIDTH  (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .idLHSRegisterIndex  (idLHSRegisterIndex),
    .idRHSRegisterIndex  (idRHSRegisterIndex),
    .idUsesLHS           (idUsesLHS),
    .idUsesRHS           (idUsesRHS),
    .exMemRead           (exMemRead),
    .exWriteRegisterIndex(exWriteRegisterIndex),
    .exBranchTaken       (exBranchTaken),
    .memRequest          (memRequest),
    .memReady            (memReady),
    .pcDontUpdate        (pcDontUpdate),
    .ifIdDontUpdate      (ifIdDontUpdate),
    .idExDontUpdate      (idExDontUpdate),
    .exMemDontUpdate     (exMemDontUpdate),
    .ifIdFlush           (ifIdFlush),
    .idExFlush           (idExFlush),
    .memWbBubble         (memWbBubble),
    .stallCycles         (stallCycles),
    .flushCount          (flushCount),
    .timeoutError        (timeoutError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    idLHSRegisterIndex   = '0;
    idRHSRegisterIndex   = '0;
    idUsesLHS            = 1'b0;
    idUsesRHS            = 1'b0;
    exMemRead            = 1'b0;
    exWriteRegisterIndex = '0;
    exBranchTaken        = 1'b0;
    memRequest           = 1'b0;
    memReady             = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    total++;
    if (stallCycles !== 4'd0) $display("FAIL reset_stall: got %0d expected 0", stallCycles);
    else passed++;
    total++;
    if (flushCount !== 4'd0) $display("FAIL reset_flush: got %0d expected 0", flushCount);
    else passed++;
    total++;
    if (timeoutError !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", timeoutError);
    else passed++;
    total++;
    if (ctl !== CTL_NONE) $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_NONE);
    else passed++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    exMemRead = 1'b1; exWriteRegisterIndex = 5'd5;
    idLHSRegisterIndex = 5'd5; idUsesLHS = 1'b1;
    #1;
    total++;
    if (ctl !== CTL_LOADUSE) $display("FAIL loaduse_lhs_ctl: got %b expected %b", ctl, CTL_LOADUSE);
    else passed++;
    tick();
    exMemRead = 1'b0;  // bubble now in EX
    #1;
    total++;
    if (ctl !== CTL_NONE) $display("FAIL loaduse_after_ctl: got %b expected %b", ctl, CTL_NONE);
    else passed++;
    total++;
    if (stallCycles !== 4'd1) $display("FAIL loaduse_stall_cnt: got %0d expected 1", stallCycles);
    else passed++;
    // rs2 match only
    clear_inputs();
    exMemRead = 1'b1; exWriteRegisterIndex = 5'd7;
    idRHSRegisterIndex = 5'd7; idUsesRHS = 1'b1; idLHSRegisterIndex = 5'd3; idUsesLHS = 1'b1;
    #1;
    total++;
    if (ctl !== CTL_LOADUSE) $display("FAIL loaduse_rhs_ctl: got %b expected %b", ctl, CTL_LOADUSE);
    else passed++;
    tick();
    clear_inputs();
    #1;
    total++;
    if (stallCycles !== 4'd2) $display("FAIL loaduse_rhs_cnt: got %0d expected 2", stallCycles);
    else passed++;
  endtask

  task automatic test_no_load_use();
    do_reset();
    exMemRead = 1'b1; exWriteRegisterIndex = 5'd0;
    idLHSRegisterIndex = 5'd0; idUsesLHS = 1'b1;
    #1;
    total++;
    if (ctl !== CTL_NONE) $display("FAIL noload_x0_ctl: got %b expected %b", ctl, CTL_NONE);
    else passed++;
    tick();
    exWriteRegisterIndex = 5'd5; idLHSRegisterIndex = 5'd5; idUsesLHS = 1'b0;
    idRHSRegisterIndex = 5'd5; idUsesRHS = 1'b0;
    #1;
    total++;
    if (ctl !== CTL_NONE) $display("FAIL noload_unused_ctl: got %b expected %b", ctl, CTL_NONE);
    else passed++;
    tick();
    clear_inputs();
    // single-cycle memory hit does not stall
    memRequest = 1'b1; memReady = 1'b1;
    #1;
    total++;
    if (ctl !== CTL_NONE) $display("FAIL mem_hit_ctl: got %b expected %b", ctl, CTL_NONE);
    else passed++;
    tick();
    clear_inputs();
    total++;
    if (stallCycles !== 4'd0) $display("FAIL noload_cnt: got %0d expected 0", stallCycles);
    else passed++;
  endtask

  task automatic test_branch();
    do_reset();
    exMemRead = 1'b1; exWriteRegisterIndex = 5'd5;
    idLHSRegisterIndex = 5'd5; idUsesLHS = 1'b1; exBranchTaken = 1'b1;
    #1;
    total++;
    if (ctl !== CTL_BRANCH) $display("FAIL branch_ctl: got %b expected %b", ctl, CTL_BRANCH);
    else passed++;
    tick();
    clear_inputs();
    total++;
    if (flushCount !== 4'd1) $display("FAIL branch_flush_cnt: got %0d expected 1", flushCount);
    else passed++;
    total++;
    if (stallCycles !== 4'd0) $display("FAIL branch_stall_cnt: got %0d expected 0", stallCycles);
    else passed++;
  endtask

  task automatic test_mem_wait();
    do_reset();
    memRequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      memReady      = (i == 3);
      exBranchTaken = (i == 1);  // branch while waiting must be ignored
      #1;
      total++;
      if (ctl !== CTL_STALL) $display("FAIL memwait_ctl[%0d]: got %b expected %b", i, ctl, CTL_STALL);
      else passed++;
      tick();
    end
    clear_inputs();
    #1;
    total++;
    if (ctl !== CTL_NONE) $display("FAIL memwait_done_ctl: got %b expected %b", ctl, CTL_NONE);
    else passed++;
    total++;
    if (stallCycles !== 4'd4) $display("FAIL memwait_stall_cnt: got %0d expected 4", stallCycles);
    else passed++;
    total++;
    if (flushCount !== 4'd0) $display("FAIL memwait_flush_cnt: got %0d expected 0", flushCount);
    else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    memRequest = 1'b1; memReady = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (timeoutError !== 1'b0) $display("FAIL timeout_early: got %b expected 0", timeoutError);
    else passed++;
    tick();
    total++;
    if (timeoutError !== 1'b1) $display("FAIL timeout_set: got %b expected 1", timeoutError);
    else passed++;
    memReady = 1'b1; exBranchTaken = 1'b1;
    tick();
    #1;
    total++;
    if (ctl !== CTL_STALL) $display("FAIL error_frozen_ctl: got %b expected %b", ctl, CTL_STALL);
    else passed++;
    total++;
    if (timeoutError !== 1'b1) $display("FAIL error_sticky: got %b expected 1", timeoutError);
    else passed++;
    for (int i = 0; i < 12; i++) tick();
    total++;
    if (stallCycles !== 4'hF) $display("FAIL stall_saturate: got %0d expected 15", stallCycles);
    else passed++;
    total++;
    if (flushCount !== 4'd0) $display("FAIL error_flush_cnt: got %0d expected 0", flushCount);
    else passed++;
    // asynchronous reset away from any clock edge
    clear_inputs();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({stallCycles, flushCount, timeoutError} !== 9'd0)
      $display("FAIL async_reset: got %0d/%0d/%b expected 0/0/0", stallCycles, flushCount, timeoutError);
    else passed++;
    total++;
    if (ctl !== CTL_NONE) $display("FAIL async_reset_ctl: got %b expected %b", ctl, CTL_NONE);
    else passed++;
    rst = 1'b0;
    memRequest = 1'b1; memReady = 1'b0;
    #1;
    total++;
    if (ctl !== CTL_STALL) $display("FAIL post_reset_ctl: got %b expected %b", ctl, CTL_STALL);
    else passed++;
    tick();
    total++;
    if (stallCycles !== 4'd1 || timeoutError !== 1'b0)
      $display("FAIL post_reset_eval: got %0d/%b expected 1/0", stallCycles, timeoutError);
    else passed++;
    clear_inputs();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_load_use();
    test_no_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
